// File: rtl/regbank_wr_arbiter.sv
// Write-port arbiter that owns a bank of reg_32bit registers, with one combinational read port.
// Define REGBANK_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.

module reg_32bit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

module regbank_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   wr_addr,
  input  logic [NREQ*32-1:0]   wr_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  input  logic [AW-1:0]        rd_addr,
  output logic [31:0]          rd_data
);

  localparam int PW    = $clog2(NREQ);
  localparam int NSLOT = 2 ** AW;

  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] gnt_next;
  logic [NREQ-1:0] eligible;
  logic            valid_reg;
  logic [AW-1:0]   addr_reg;
  logic [31:0]     data_reg;
  logic [AW-1:0]   addr_acc [NREQ+1];
  logic [31:0]     data_acc [NREQ+1];

  // The requester already holding the grant is masked so it cannot win back-to-back.
  assign eligible = req & ~gnt_reg;

`ifdef REGBANK_RR_EN
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     ptr_next;
  logic [PW-1:0]     ptr_acc [NREQ+1];
  logic [2*NREQ-1:0] elig_dbl;
  logic [2*NREQ-1:0] unrot_dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   pick;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    elig_dbl  = {eligible, eligible} >> ptr_reg;
    rot       = elig_dbl[NREQ-1:0];
    pick      = rot & (~rot + NREQ'(1));
    unrot_dbl = {pick, pick} << ptr_reg;
    gnt_next  = unrot_dbl[2*NREQ-1:NREQ];
  end

  assign ptr_acc[0] = '0;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ptr
    assign ptr_acc[gi+1] = ptr_acc[gi] | (gnt_next[gi] ? PW'((gi + 1) % NREQ) : '0);
  end

  assign ptr_next = (|gnt_next) ? ptr_acc[NREQ] : ptr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end
`else
  assign gnt_next = eligible & (~eligible + NREQ'(1));
`endif

  // One-hot grant drives an AND-OR mux for the winner's address and data.
  assign addr_acc[0] = '0;
  assign data_acc[0] = '0;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
    assign addr_acc[gi+1] = addr_acc[gi] | ({AW{gnt_next[gi]}} & wr_addr[gi*AW +: AW]);
    assign data_acc[gi+1] = data_acc[gi] | ({32{gnt_next[gi]}} & wr_data[gi*32 +: 32]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      gnt_reg   <= gnt_next;
      valid_reg <= |gnt_next;
      addr_reg  <= addr_acc[NREQ];
      data_reg  <= data_acc[NREQ];
    end
  end

  assign gnt  = gnt_reg;
  assign busy = valid_reg;

  logic [31:0] bank_q  [NREGS];
  logic [31:0] bank_rd [NSLOT];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bank
    logic we;
    assign we = valid_reg && (addr_reg == AW'(gi));
    reg_32bit u_reg (
      .clk   (clk),
      .reset (reset),
      .d     (we ? data_reg : bank_q[gi]),
      .q     (bank_q[gi])
    );
  end

  // Addresses beyond the bank read as zero; writes to them match no register.
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_rd
    if (gi < NREGS) begin : g_real
      assign bank_rd[gi] = bank_q[gi];
    end else begin : g_empty
      assign bank_rd[gi] = '0;
    end
  end

  assign rd_data = bank_rd[rd_addr];

endmodule
